pdec_updt_us_pl: RTL and testbench

//  Partial-sum (u_s) update engine for the SCL polar decoder; parametrised successor of the fixed 8-path u_s updater.
//  Per path, it XOR-combines the current hard decision with stored left-sibling partial sums from stage cur_stage up to cur_depth.
//  The combine chain is cut into passes of PIPE_STG stages per clock, so long codes close timing.

---
 rtl/pdec_updt_us_pl_if.sv | 31 +++
 rtl/pdec_updt_us_pl.sv | 157 +++++++++++++++
 tb/tb_pdec_updt_us_pl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pdec_updt_us_pl_if.sv
// Handshake and data bundle between the SCL controller and the u_s partial-sum updater.
interface pdec_updt_us_pl_if #(
  parameter int unsigned NUM_PATH = 8,
  parameter int unsigned DEPTH_W  = 8,
  parameter int unsigned PTR_W    = 3,
  parameter int unsigned NUM_US   = 2**DEPTH_W
);
  logic                              clr;
  logic                              st;
  logic [3:0]                        cur_stage;
  logic [3:0]                        cur_depth;
  logic [2:0]                        cur_jump_type;
  logic [2*NUM_PATH-1:0]             path_valid;
  logic [4*NUM_PATH-1:0]             hard_bit;
  logic [PTR_W*DEPTH_W*NUM_PATH-1:0] us_ptr;
  logic                              busy;
  logic                              done;
  logic                              err;
  logic                              clk_en;
  logic [NUM_US*NUM_PATH-1:0]        us_data;

  modport master (
    output clr, st, cur_stage, cur_depth, cur_jump_type, path_valid, hard_bit, us_ptr,
    input  busy, done, err, clk_en, us_data
  );

  modport slave (
    input  clr, st, cur_stage, cur_depth, cur_jump_type, path_valid, hard_bit, us_ptr,
    output busy, done, err, clk_en, us_data
  );
endinterface

// File: rtl/pdec_updt_us_pl.sv
// Pipelined u_s partial-sum updater for an L-path SCL polar decoder: walks the XOR
// combine chain PIPE_STG stages per clock, then writes each valid path's segment once.
module pdec_updt_us_pl #(
  parameter int unsigned NUM_PATH = 8,
  parameter int unsigned DEPTH_W  = 8,
  parameter int unsigned NUM_US   = 256,
  parameter int unsigned PIPE_STG = 4,
  parameter int unsigned PTR_W    = 3
) (
  input  logic clk,
  input  logic rst_n,
  pdec_updt_us_pl_if.slave bus
);

  localparam int unsigned       SW   = 5;
  localparam logic [SW-1:0]     PSTG = SW'(PIPE_STG);
  localparam int unsigned       PW   = PTR_W*DEPTH_W;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [NUM_US-1:0]   mem_q   [NUM_PATH];
  logic [NUM_US-1:0]   mem_d   [NUM_PATH];
  logic [NUM_US-1:0]   chain_q [NUM_PATH];
  logic [NUM_US-1:0]   chain_d [NUM_PATH];
  logic [PW-1:0]       ptr_q   [NUM_PATH];
  logic [NUM_PATH-1:0] inv_q;
  logic [3:0]          depth_q;
  logic [SW-1:0]       sidx_q;
  logic                illegal_q;
  logic                done_q, done_d, err_q, err_d;
  logic                snap, wr_en, last;

  // 2**lg ones in the low bits
  function automatic logic [NUM_US-1:0] lo_mask(input int unsigned lg);
    logic [NUM_US-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_US; i++)
      if ((i >> lg) == 0) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [NUM_US-1:0] seed(input logic [3:0] hb, input logic [3:0] stg,
                                             input logic [2:0] jt);
    logic [NUM_US-1:0] v;
    v = '0;
    if (jt == 3'd0)                     v = '0;
    else if (stg == 4'd2 && jt >= 3'd2) v = NUM_US'(hb);
    else if (hb[3])                     v = lo_mask(32'(stg));
    return v;
  endfunction

  assign last = illegal_q || ((sidx_q + PSTG) >= {1'b0, depth_q});

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.clk_en = bus.st | bus.busy | done_q;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PATH; p++)
      bus.us_data[p*NUM_US +: NUM_US] = mem_q[p];
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    snap    = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.st) begin
        snap    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (bus.st) err_d = 1'b1;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (illegal_q) err_d = 1'b1;
          else           wr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory is only written on the final edge, so every pass reads pre-operation u_s.
  always_comb begin : comb_chain
    logic [NUM_US-1:0] c, in0, seg, base;
    logic [SW-1:0]     s;
    logic [PTR_W-1:0]  src;
    c = '0; in0 = '0; seg = '0; base = '0; s = '0; src = '0;
    for (int unsigned p = 0; p < NUM_PATH; p++) begin
      c = chain_q[p];
      for (int unsigned k = 0; k < PIPE_STG; k++) begin
        s = sidx_q + SW'(k);
        if (s < {1'b0, depth_q}) begin
          src = ptr_q[p][32'(s)*PTR_W +: PTR_W];
          in0 = (mem_q[src] >> (32'd1 << s)) & lo_mask(32'(s));
          c   = (c << (32'd1 << s)) | (in0 ^ c);
        end
      end
      chain_d[p] = c;
      base = bus.clr ? '0 : mem_q[p];
      if (wr_en && !inv_q[p]) begin
        if (depth_q == 4'(DEPTH_W)) begin
          mem_d[p] = c;
        end else begin
          seg      = lo_mask(32'(depth_q)) << (32'd1 << depth_q);
          mem_d[p] = (base & ~seg) | ((c << (32'd1 << depth_q)) & seg);
        end
      end else begin
        mem_d[p] = base;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sidx_q    <= '0;
      depth_q   <= '0;
      illegal_q <= 1'b0;
      inv_q     <= '0;
      for (int unsigned p = 0; p < NUM_PATH; p++) begin
        mem_q[p]   <= '0;
        chain_q[p] <= '0;
        ptr_q[p]   <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      for (int unsigned p = 0; p < NUM_PATH; p++)
        mem_q[p] <= mem_d[p];
      if (snap) begin
        sidx_q    <= {1'b0, bus.cur_stage};
        depth_q   <= bus.cur_depth;
        illegal_q <= (bus.cur_stage > bus.cur_depth) || (bus.cur_depth > 4'(DEPTH_W));
        for (int unsigned p = 0; p < NUM_PATH; p++) begin
          chain_q[p] <= seed(bus.hard_bit[4*p +: 4], bus.cur_stage, bus.cur_jump_type);
          ptr_q[p]   <= bus.us_ptr[p*PW +: PW];
          inv_q[p]   <= bus.path_valid[2*p+1];
        end
      end else if (state_q == RUN && !last) begin
        sidx_q <= sidx_q + PSTG;
        for (int unsigned p = 0; p < NUM_PATH; p++)
          chain_q[p] <= chain_d[p];
      end
    end
  end

endmodule

// File: tb/tb_pdec_updt_us_pl.sv
// Directed bench for pdec_updt_us_pl (L=8, DEPTH_W=8, PIPE_STG=4).
`define CHK(tag, obs, exp) begin n_total++; assert ((obs) === (exp)) n_pass++; else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); end

module tb_pdec_updt_us_pl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;

  always #5 clk = ~clk;

  pdec_updt_us_pl_if #(.NUM_PATH(8), .DEPTH_W(8), .PTR_W(3), .NUM_US(256)) bus ();

  pdec_updt_us_pl #(.NUM_PATH(8), .DEPTH_W(8), .NUM_US(256), .PIPE_STG(4), .PTR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.err === 1'b1)  err_cnt++;
  end

  function automatic logic [255:0] us(input int p);
    return bus.us_data[p*256 +: 256];
  endfunction

  // Reference XOR tree built bit by bit from one source path.
  function automatic logic [255:0] golden(input logic [255:0] src, input logic hb3,
                                          input int stage, input int depth);
    logic [255:0] c, nc;
    int w;
    c = '0;
    w = 1 << stage;
    for (int i = 0; i < w; i++) c[i] = hb3;
    for (int s = stage; s < depth; s++) begin
      w  = 1 << s;
      nc = '0;
      for (int i = 0; i < w; i++) begin
        nc[i]   = src[w+i] ^ c[i];
        nc[w+i] = c[i];
      end
      c = nc;
    end
    return c;
  endfunction

  task automatic set_ptr_all(input int src);
    logic [2:0] v;
    v = 3'(src);
    for (int p = 0; p < 8; p++)
      for (int s = 0; s < 8; s++)
        bus.us_ptr[p*24 + s*3 +: 3] = v;
  endtask

  task automatic setup(input int stg, input int dep, input int jt, input logic [31:0] hb);
    bus.cur_stage     = 4'(stg);
    bus.cur_depth     = 4'(dep);
    bus.cur_jump_type = 3'(jt);
    bus.hard_bit      = hb;
  endtask

  task automatic run_op(input int clr_at, input int st2_at, output int cyc, output logic busy1);
    @(negedge clk);
    bus.st = 1'b1;
    @(posedge clk);
    #1 bus.st = 1'b0;
    cyc   = -1;
    busy1 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) busy1 = bus.busy;
      bus.clr = (n == clr_at);
      bus.st  = (n == st2_at);
      if (bus.done === 1'b1) begin
        cyc = n;
        break;
      end
    end
    bus.clr = 1'b0;
    bus.st  = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  initial begin
    int           cyc, d0, e0;
    logic         b1;
    logic [255:0] pre, g, ones, half;
    ones = '1;
    half = {128'd0, {128{1'b1}}};

    bus.clr = 1'b0; bus.st = 1'b0; bus.path_valid = '0; bus.us_ptr = '0;
    setup(0, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    `CHK("rst_busy", bus.busy, 1'b0)
    `CHK("rst_done", bus.done, 1'b0)
    `CHK("rst_err", bus.err, 1'b0)
    `CHK("rst_clk_en", bus.clk_en, 1'b0)
    `CHK("rst_us_zero", |bus.us_data, 1'b0)
    rst_n = 1'b1;

    // depth 0: bit 1 takes hb[3]
    setup(0, 0, 1, 32'h0000_0008);
    run_op(0, 0, cyc, b1);
    `CHK("t1_latency", cyc, 2)
    `CHK("t1_busy_run", b1, 1'b1)
    `CHK("t1_path0", us(0), 256'h2)
    `CHK("t1_path1", us(1), 256'h0)
    `CHK("t1_path7", us(7), 256'h0)
    @(negedge clk);
    `CHK("t1_idle_busy", bus.busy, 1'b0)
    `CHK("t1_no_err", err_cnt, 0)

    // preload path0 = ones in [127:0]
    pulse_clr();
    `CHK("clr_zero", |bus.us_data, 1'b0)
    set_ptr_all(0);
    setup(0, 8, 1, 32'h0000_0008);
    run_op(0, 0, cyc, b1);
    `CHK("preA_latency", cyc, 3)
    `CHK("preA_path0", us(0), ones)
    `CHK("preA_path1", us(1), 256'h0)
    setup(7, 7, 1, 32'h0);
    run_op(0, 0, cyc, b1);
    `CHK("preB_latency", cyc, 2)
    `CHK("preB_path0", us(0), half)

    // full-depth XOR tree, N=2
    pre = us(0);
    setup(0, 8, 1, 32'h0000_0008);
    run_op(0, 0, cyc, b1);
    g = golden(pre, 1'b1, 0, 8);
    `CHK("t2_latency", cyc, 3)
    `CHK("t2_path0", us(0), g)
    `CHK("t2_path0_byte0", us(0) & 256'hFF, 256'h96)
    `CHK("t2_path1", us(1), golden(pre, 1'b0, 0, 8))

    // jump-type seeding at stage 2
    setup(2, 2, 2, 32'h0000_000A);
    run_op(0, 0, cyc, b1);
    `CHK("t3_jt2", us(0), (g & ~256'hF0) | 256'hA0)
    setup(2, 2, 1, 32'h0000_000A);
    run_op(0, 0, cyc, b1);
    `CHK("t3_jt1", us(0), (g & ~256'hF0) | 256'hF0)
    setup(2, 2, 0, 32'h0000_000A);
    run_op(0, 0, cyc, b1);
    `CHK("t3_jt0", us(0), g & ~256'hF0)
    `CHK("t3_latency", cyc, 2)

    // invalid path and cross-path pointer
    pulse_clr();
    setup(2, 2, 2, 32'h8765_4321);
    run_op(0, 0, cyc, b1);
    `CHK("t4_pre_path5", us(5), 256'h60)
    bus.path_valid = 16'hC000;
    for (int p = 0; p < 8; p++) bus.us_ptr[p*24 + 6 +: 3] = 3'(p);
    bus.us_ptr[3*24 + 6 +: 3] = 3'd5;
    setup(2, 3, 1, 32'h0000_8000);
    run_op(0, 0, cyc, b1);
    `CHK("t4_latency", cyc, 2)
    `CHK("t4_path0", us(0), 256'h110)
    `CHK("t4_path6", us(6), 256'h770)
    `CHK("t4_path3_xptr", us(3), 256'hF940)
    `CHK("t4_path7_inv", us(7), 256'h80)

    // st while busy
    pulse_clr();
    bus.path_valid = '0;
    set_ptr_all(0);
    d0 = done_cnt; e0 = err_cnt;
    setup(0, 8, 1, 32'h0000_0008);
    run_op(0, 1, cyc, b1);
    repeat (3) @(negedge clk);
    `CHK("t5_latency", cyc, 3)
    `CHK("t5_err_once", err_cnt - e0, 1)
    `CHK("t5_done_once", done_cnt - d0, 1)
    `CHK("t5_path0", us(0), ones)
    `CHK("t5_path1", us(1), 256'h0)

    // illegal stage>depth and depth>DEPTH_W
    d0 = done_cnt; e0 = err_cnt;
    setup(5, 3, 1, 32'hFFFF_FFFF);
    run_op(0, 0, cyc, b1);
    repeat (2) @(negedge clk);
    `CHK("t5_ill_latency", cyc, 2)
    `CHK("t5_ill_err", err_cnt - e0, 1)
    `CHK("t5_ill_done", done_cnt - d0, 1)
    `CHK("t5_ill_mem", us(0), ones)
    e0 = err_cnt;
    setup(0, 9, 1, 32'hFFFF_FFFF);
    run_op(0, 0, cyc, b1);
    repeat (2) @(negedge clk);
    `CHK("t5_deep_latency", cyc, 2)
    `CHK("t5_deep_err", err_cnt - e0, 1)
    `CHK("t5_deep_mem1", us(1), 256'h0)

    // reset during RUN
    setup(0, 8, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    bus.st = 1'b1;
    @(posedge clk);
    #1 bus.st = 1'b0;
    @(negedge clk);
    `CHK("t6_busy_before_rst", bus.busy, 1'b1)
    rst_n = 1'b0;
    #1;
    `CHK("t6_rst_busy", bus.busy, 1'b0)
    `CHK("t6_rst_us", |bus.us_data, 1'b0)
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    `CHK("t6_no_done", done_cnt - d0, 0)
    `CHK("t6_idle", bus.busy, 1'b0)

    // clr mid-RUN wipes earlier data; final write lands on cleared memory
    setup(2, 2, 2, 32'h0000_00F0);
    run_op(0, 0, cyc, b1);
    `CHK("t6_pre_path1", us(1), 256'hF0)
    set_ptr_all(2);
    setup(0, 7, 1, 32'h8888_8888);
    run_op(1, 0, cyc, b1);
    `CHK("t6_clr_latency", cyc, 3)
    `CHK("t6_clr_path1", us(1), ~half)
    `CHK("t6_clr_path5", us(5), ~half)
    @(negedge clk);
    `CHK("t6_clk_en_idle", bus.clk_en, 1'b0)

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
